// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// score_keeper : rhythm-game scoring FSM (IDLE/PLAY/DONE) that tracks the total
//                score, the current combo and the best combo of the song.
// Optional macro COMBO_BONUS_EN adds a combo-based points multiplier (x1/x2/x4).
// Revision : 1.0
// ============================================================================
module score_keeper #(
    parameter int unsigned PERFECT_PTS = 10,
    parameter int unsigned GOOD_PTS    = 5,
    parameter int unsigned MAX_SCORE   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        hit_valid,
    input  logic [1:0]  hit_grade,
    output logic [31:0] total,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic        playing,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]  c_grade_miss    = 2'b00;
    localparam logic [1:0]  c_grade_good    = 2'b01;
    localparam logic [1:0]  c_grade_perfect = 2'b10;
    localparam logic [7:0]  c_combo_max     = 8'hFF;
    localparam logic [32:0] c_max_score     = 33'(MAX_SCORE);

    state_t      state_q, state_d;
    logic [31:0] total_q, total_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  max_combo_q, max_combo_d;

    logic [31:0] w_base_pts;
    logic [31:0] w_points;
    logic [32:0] w_sum;
    logic [31:0] w_total_sat;

    assign w_base_pts = (hit_grade == c_grade_perfect) ? 32'(PERFECT_PTS) : 32'(GOOD_PTS);

`ifdef COMBO_BONUS_EN
    // Multiplier is taken from the combo before the current hit is counted.
    logic [31:0] w_mult;
    always_comb begin
        if (combo_q < 8'd10) begin
            w_mult = 32'd1;
        end else if (combo_q < 8'd50) begin
            w_mult = 32'd2;
        end else begin
            w_mult = 32'd4;
        end
    end
    assign w_points = w_base_pts * w_mult;
`else
    assign w_points = w_base_pts;
`endif

    // One extra bit keeps the addition from wrapping before the ceiling clamp.
    assign w_sum       = {1'b0, total_q} + {1'b0, w_points};
    assign w_total_sat = (w_sum > c_max_score) ? c_max_score[31:0] : w_sum[31:0];

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_PLAY;
                    total_d     = '0;
                    combo_d     = '0;
                    max_combo_d = '0;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_d = S_DONE;
                end
                if (hit_valid) begin
                    case (hit_grade)
                        c_grade_good, c_grade_perfect: begin
                            combo_d     = (combo_q == c_combo_max) ? combo_q : combo_q + 8'd1;
                            max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
                            total_d     = w_total_sat;
                        end
                        c_grade_miss: begin
                            combo_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    assign total     = total_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign playing   = (state_q == S_PLAY);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// tb_score_keeper : scoreboard bench for score_keeper; directed vectors push
//                   expected outputs, a negedge monitor pops and compares.
// Revision : 1.0
// ============================================================================
module tb_score_keeper;

    localparam logic [1:0] c_miss    = 2'b00;
    localparam logic [1:0] c_good    = 2'b01;
    localparam logic [1:0] c_perfect = 2'b10;
    localparam logic [1:0] c_rsvd    = 2'b11;

`ifdef COMBO_BONUS_EN
    localparam int c_exp_11 = 120;
    localparam int c_exp_12 = 140;
`else
    localparam int c_exp_11 = 110;
    localparam int c_exp_12 = 120;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        hit_valid;
    logic [1:0]  hit_grade;
    logic [31:0] total;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        playing;
    logic        done;

    typedef struct packed {
        logic [31:0] total;
        logic [7:0]  combo;
        logic [7:0]  maxc;
        logic        playing;
        logic        done;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;
    int    errors = 0;
    int    checks = 0;

    score_keeper dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .hit_valid (hit_valid),
        .hit_grade (hit_grade),
        .total     (total),
        .combo     (combo),
        .max_combo (max_combo),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            checks++;
            if ({total, combo, max_combo, playing, done} !== mon_e) begin
                errors++;
                $display("FAIL %s: got total=%0d combo=%0d max_combo=%0d playing=%0b done=%0b, expected total=%0d combo=%0d max_combo=%0d playing=%0b done=%0b",
                         mon_nm, total, combo, max_combo, playing, done,
                         mon_e.total, mon_e.combo, mon_e.maxc, mon_e.playing, mon_e.done);
            end
        end
    end

    task automatic chk(input string nm, input int t, input int c, input int m,
                       input logic p, input logic d);
        exp_t e;
        e.total   = 32'(t);
        e.combo   = 8'(c);
        e.maxc    = 8'(m);
        e.playing = p;
        e.done    = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Drives one cycle of inputs; returns one time unit after the sampling edge.
    task automatic cyc(input logic s, input logic p, input logic hv, input logic [1:0] g);
        start     = s;
        stop      = p;
        hit_valid = hv;
        hit_grade = g;
        @(posedge clk);
        #1;
        start     = 1'b0;
        stop      = 1'b0;
        hit_valid = 1'b0;
        hit_grade = 2'b00;
    endtask

    task automatic hits(input int n, input logic [1:0] g);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1, g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        hit_valid = 1'b0;
        hit_grade = 2'b00;
        @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("idle_hit_ignored", 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, c_miss);
        cyc(1'b0, 1'b0, 1'b0, c_miss);
        chk("idle_wait", 0, 0, 0, 1'b0, 1'b0);

        cyc(1'b1, 1'b0, 1'b1, c_perfect);
        chk("start_hit_ignored", 0, 0, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("perfect1", 10, 1, 1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("perfect2", 20, 2, 2, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("perfect3", 30, 3, 3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_good);
        chk("three_perfect_one_good", 35, 4, 4, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, c_miss);
        chk("start_in_play", 35, 4, 4, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_rsvd);
        chk("reserved_grade", 35, 4, 4, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, c_miss);
        chk("stop", 35, 4, 4, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("done_hit_ignored", 35, 4, 4, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, c_miss);
        chk("restart_clears", 0, 0, 0, 1'b1, 1'b0);

        hits(5, c_good);
        chk("five_goods", 25, 5, 5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_miss);
        chk("miss", 25, 0, 5, 1'b1, 1'b0);
        hits(2, c_good);
        chk("goods_after_miss", 35, 2, 5, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, c_miss);
        cyc(1'b1, 1'b0, 1'b0, c_miss);
        chk("restart2", 0, 0, 0, 1'b1, 1'b0);
        hits(10, c_perfect);
        chk("ten_perfects", 100, 10, 10, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("perfect11", c_exp_11, 11, 11, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("perfect12", c_exp_12, 12, 12, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, c_miss);
        cyc(1'b1, 1'b0, 1'b0, c_miss);
        hits(1000, c_perfect);
        chk("saturate_1000", 9999, 255, 255, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("saturate_hold", 9999, 255, 255, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_miss);
        chk("saturate_miss", 9999, 0, 255, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, c_good);
        chk("saturate_good", 9999, 1, 255, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, c_miss);
        cyc(1'b1, 1'b0, 1'b0, c_miss);
        hits(5, c_perfect);
        chk("fifty_points", 50, 5, 5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, c_miss);
        #2;
        reset = 1'b1;
        chk("async_reset", 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("idle_hit_after_reset", 0, 0, 0, 1'b0, 1'b0);

        cyc(1'b1, 1'b0, 1'b0, c_miss);
        chk("start3", 0, 0, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, c_perfect);
        chk("hit_with_stop", 10, 1, 1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, c_perfect);
        chk("after_done_perfect", 10, 1, 1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, c_miss);
        chk("after_done_miss", 10, 1, 1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, c_miss);
        chk("restart_from_done", 0, 0, 0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
